// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Start/stop framed serial-in, parallel-out receiver with a
//               valid/ready output register, frame-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int             c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [c_cw-1:0]  r_count;
    logic             r_dir;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_count   <= '0;
            r_dir     <= 1'b0;
            q         <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (sin_en && !sin) begin
                        r_state <= S_DATA;
                        r_count <= '0;
                        r_dir   <= dir;
                    end
                end
                S_DATA: begin
                    if (sin_en) begin
                        if (r_dir) begin
                            r_sr <= {r_sr[WIDTH-2:0], sin};
                        end else begin
                            r_sr <= {sin, r_sr[WIDTH-1:1]};
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == c_last) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (sin_en) begin
                        r_state <= S_IDLE;
                        if (!sin) begin
                            frame_err <= 1'b1;
                        end else if (!q_valid || q_ready) begin
                            // A load in the consume cycle keeps q_valid high.
                            q       <= r_sr;
                            q_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Directed and randomized bench for serial_frame_rx with a
//               word-level reference model of the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sin;
    logic         sin_en;
    logic         dir;
    logic [W-1:0] q;
    logic         q_valid;
    logic         q_ready;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents of the output register.
    logic [W-1:0] mq;
    logic         mv;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_en    (sin_en),
        .dir       (dir),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        @(negedge clk);
        sin    = b;
        sin_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin_en  = 1'b0;
            sin     = 1'($urandom);
            q_ready = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},       32'(q),       32'(mq));
        check({tag, ".q_valid"}, 32'(q_valid), 32'(mv));
    endtask

    // Sends one frame carrying word 'data'; wire order derives from the frame direction.
    task automatic send_frame(input string tag, input logic [W-1:0] data, input logic d,
                              input logic stopb, input int gap, input logic rdy,
                              input logic toggle);
        logic efe;
        logic eov;
        efe = 1'b0;
        eov = 1'b0;
        dir = d;
        strobe(1'b0);
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        if (toggle) dir = ~d;
        for (int i = 0; i < W; i++) begin
            idle(gap);
            strobe(d ? data[W-1-i] : data[i]);
            if (toggle) dir = ~dir;
        end
        idle(gap);
        @(negedge clk);
        sin     = stopb;
        sin_en  = 1'b1;
        q_ready = rdy;
        @(posedge clk);
        #1;
        if (stopb) begin
            if (!mv || rdy) begin
                mq = data;
                mv = 1'b1;
            end else begin
                eov = 1'b1;
            end
        end else begin
            efe = 1'b1;
            if (mv && rdy) mv = 1'b0;
        end
        check_model(tag);
        check({tag, ".frame_err"}, 32'(frame_err), 32'(efe));
        check({tag, ".overrun"},   32'(overrun),   32'(eov));
        check({tag, ".busy_end"},  32'(busy),      32'd0);
        idle(1);
        check({tag, ".fe_clear"}, 32'(frame_err), 32'd0);
        check({tag, ".ov_clear"}, 32'(overrun),   32'd0);
        check_model({tag, ".hold"});
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        sin_en  = 1'b0;
        q_ready = 1'b1;
        @(posedge clk);
        #1;
        mv = 1'b0;
        check({tag, ".consume"}, 32'(q_valid), 32'd0);
        @(negedge clk);
        q_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rdata;
        reset   = 1'b0;
        sin     = 1'b1;
        sin_en  = 1'b0;
        dir     = 1'b0;
        q_ready = 1'b0;
        mq      = '0;
        mv      = 1'b0;
        #3;
        check("rst.q",         32'(q),         32'd0);
        check("rst.q_valid",   32'(q_valid),   32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.frame_err", 32'(frame_err), 32'd0);
        check("rst.overrun",   32'(overrun),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Test 1: LSB-first word, then a consume.
        send_frame("t1", 4'b1001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("t1.literal", 32'(q), 32'h9);
        consume("t1");

        // Test 2: MSB-first word, with and without strobe gaps.
        send_frame("t2a", 4'b1011, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        consume("t2a");
        send_frame("t2b", 4'b1011, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        check("t2b.literal", 32'(q), 32'hb);
        consume("t2b");

        // Test 3: bad stop bit leaves the output register alone.
        send_frame("t3", 4'b1111, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("t3.literal", 32'(q), 32'hb);

        // Test 4: overrun, then a load in the consume cycle.
        send_frame("t4a", 4'b1001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_frame("t4b", 4'b0110, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        check("t4b.literal", 32'(q), 32'h9);
        send_frame("t4c", 4'b0110, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        check("t4c.literal", 32'(q), 32'h6);
        consume("t4c");

        // Test 5: asynchronous reset mid-frame.
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        #2;
        reset  = 1'b0;
        sin_en = 1'b0;
        #1;
        mq = '0;
        mv = 1'b0;
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.q",    32'(q),    32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        send_frame("t5", 4'b1001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        consume("t5");

        // Test 6: idle-high line, then a frame with dir toggling.
        for (int i = 0; i < 20; i++) strobe(1'b1);
        check("t6.busy",      32'(busy),      32'd0);
        check("t6.q_valid",   32'(q_valid),   32'd0);
        check("t6.frame_err", 32'(frame_err), 32'd0);
        send_frame("t6", 4'b1100, 1'b0, 1'b1, 1, 1'b0, 1'b1);
        check("t6.literal", 32'(q), 32'hc);
        consume("t6");

        // Randomized frames against the model.
        for (int n = 0; n < 40; n++) begin
            rdata = W'($urandom);
            send_frame("rnd", rdata, 1'($urandom), ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 2), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) consume("rnd");
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
